lane_word_aligner: RTL and testbench

Parametrised successor to the half-bit lane slipper. Deserialises per-lane DDR rise/fall bit pairs into WORD_W-bit ADC sample words, with a per-lane bit offset of 0..WORD_W-1. It supports manual slip requests and, optionally, an automatic training FSM that hunts for a known frame pattern. It sits after DDR capture/retiming and before the sample-word FIFO.

---
 rtl/lane_align_pkg.sv | 25 ++
 rtl/lane_align_fsm.sv | 103 ++++++++++
 rtl/lane_word_aligner.sv | 114 +++++++++++
 tb/tb_lane_word_aligner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lane_align_pkg.sv
// rtl/lane_align_pkg.sv - shared state type, width helpers and default constants for lane_word_aligner
package lane_align_pkg;

  localparam int WORD_W_DEF       = 16;
  localparam int MATCH_WORDS_DEF  = 4;
  localparam int SETTLE_WORDS_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED,
    ST_FAIL
  } lane_state_t;

  function automatic int ow_width(input int word_w);
    return (word_w > 2) ? $clog2(word_w) : 1;
  endfunction

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/lane_align_fsm.sv
// rtl/lane_align_fsm.sv - one lane's training FSM: settle, pattern check, slip request, lock/fail status
module lane_align_fsm
  import lane_align_pkg::*;
#(
  parameter int WORD_W       = WORD_W_DEF,
  parameter int MATCH_WORDS  = MATCH_WORDS_DEF,
  parameter int SETTLE_WORDS = SETTLE_WORDS_DEF
) (
  input  logic              dco_clk,
  input  logic              rst,
  input  logic              i_boundary,
  input  logic              i_train_start,
  input  logic [WORD_W-1:0] i_cand,
  input  logic [WORD_W-1:0] i_pattern,
  output logic              o_slip,
  output logic              o_locked,
  output logic              o_fail,
  output logic              o_busy
);

  localparam int SW = cnt_width(WORD_W - 1);
  localparam int MW = cnt_width(MATCH_WORDS);
  localparam int TW = cnt_width(SETTLE_WORDS);
  localparam logic [SW-1:0] SLIP_LAST   = SW'(WORD_W - 1);
  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_WORDS - 1);
  localparam logic [TW-1:0] SETTLE_DONE = TW'(SETTLE_WORDS);

  lane_state_t   r_state;
  logic [SW-1:0] r_slip_cnt;
  logic [MW-1:0] r_match_cnt;
  logic [TW-1:0] r_settle_cnt;
  logic          r_slip;
  logic          r_locked;
  logic          r_fail;
  logic          r_busy;
  logic          w_match;

  assign w_match = (i_cand == i_pattern);

  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_slip_cnt   <= '0;
      r_match_cnt  <= '0;
      r_settle_cnt <= '0;
      r_slip       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_slip <= 1'b0;
      if (i_train_start) begin
        r_state      <= ST_SETTLE;
        r_slip_cnt   <= '0;
        r_match_cnt  <= '0;
        r_settle_cnt <= '0;
        r_locked     <= 1'b0;
        r_fail       <= 1'b0;
        r_busy       <= 1'b1;
      end else begin
        case (r_state)
          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_DONE) begin
              r_state <= ST_CHECK;
            end else if (i_boundary) begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          ST_CHECK: begin
            if (i_boundary) begin
              if (w_match) begin
                r_match_cnt <= r_match_cnt + 1'b1;
                if (r_match_cnt == MATCH_LAST) begin
                  r_state  <= ST_LOCKED;
                  r_locked <= 1'b1;
                  r_busy   <= 1'b0;
                end
              end else if (r_slip_cnt == SLIP_LAST) begin
                r_state <= ST_FAIL;
                r_fail  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                // Offset moves next cycle, well before the next settle boundary.
                r_slip       <= 1'b1;
                r_slip_cnt   <= r_slip_cnt + 1'b1;
                r_match_cnt  <= '0;
                r_settle_cnt <= '0;
                r_state      <= ST_SETTLE;
              end
            end
          end
          default: r_state <= r_state;
        endcase
      end
    end
  end

  assign o_slip   = r_slip;
  assign o_locked = r_locked;
  assign o_fail   = r_fail;
  assign o_busy   = r_busy;

endmodule

// File: rtl/lane_word_aligner.sv
// rtl/lane_word_aligner.sv - per-lane DDR bit-pair deserialiser with bit-offset word alignment
// Training FSMs are built only when LANE_AUTO_TRAIN_EN is defined; otherwise manual slip only.
module lane_word_aligner
  import lane_align_pkg::*;
#(
  parameter int  LANES        = 8,
  parameter int  WORD_W       = WORD_W_DEF,
  parameter int  MATCH_WORDS  = MATCH_WORDS_DEF,
  parameter int  SETTLE_WORDS = SETTLE_WORDS_DEF,
  localparam int OW           = ow_width(WORD_W)
) (
  input  logic                    dco_clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        in_rise,
  input  logic [LANES-1:0]        in_fall,
  input  logic [LANES-1:0]        bitslip_pulse,
  input  logic                    train_start,
  input  logic [WORD_W-1:0]       train_pattern,
  output logic [LANES*WORD_W-1:0] out_word,
  output logic                    out_valid,
  output logic [LANES*OW-1:0]     slip_offset,
  output logic [LANES-1:0]        lane_locked,
  output logic [LANES-1:0]        lane_fail,
  output logic                    train_busy
);

  localparam int PW = cnt_width(WORD_W / 2 - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(WORD_W / 2 - 1);
  localparam logic [OW-1:0] OFF_LAST   = OW'(WORD_W - 1);

  logic [PW-1:0]    r_phase;
  logic             r_out_valid;
  logic             w_boundary;
  logic [LANES-1:0] w_busy;

  assign w_boundary = (r_phase == PHASE_LAST);

  always_ff @(posedge dco_clk or posedge rst) begin
    if (rst) begin
      r_phase     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_phase     <= w_boundary ? '0 : r_phase + 1'b1;
      r_out_valid <= w_boundary;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [2*WORD_W-1:0] r_sr;
    logic [2*WORD_W-1:0] w_sr_next;
    logic [OW-1:0]       r_offset;
    logic [WORD_W-1:0]   r_word;
    logic [WORD_W-1:0]   w_cand;
    logic                w_fsm_slip;
    logic                w_step;

    // Newest bit at sr[0]; the word is taken from the post-update view.
    assign w_sr_next = {r_sr[2*WORD_W-3:0], in_rise[i], in_fall[i]};
    assign w_cand    = w_sr_next[r_offset +: WORD_W];
    assign w_step    = w_fsm_slip | (bitslip_pulse[i] & ~w_busy[i]);

    always_ff @(posedge dco_clk or posedge rst) begin
      if (rst) begin
        r_sr     <= '0;
        r_offset <= '0;
        r_word   <= '0;
      end else begin
        r_sr <= w_sr_next;
        if (w_step) begin
          r_offset <= (r_offset == OFF_LAST) ? '0 : r_offset + 1'b1;
        end
        if (w_boundary) begin
          r_word <= w_cand;
        end
      end
    end

    assign out_word[i*WORD_W +: WORD_W] = r_word;
    assign slip_offset[i*OW +: OW]      = r_offset;

`ifdef LANE_AUTO_TRAIN_EN
    lane_align_fsm #(
      .WORD_W       (WORD_W),
      .MATCH_WORDS  (MATCH_WORDS),
      .SETTLE_WORDS (SETTLE_WORDS)
    ) u_fsm (
      .dco_clk       (dco_clk),
      .rst           (rst),
      .i_boundary    (w_boundary),
      .i_train_start (train_start),
      .i_cand        (w_cand),
      .i_pattern     (train_pattern),
      .o_slip        (w_fsm_slip),
      .o_locked      (lane_locked[i]),
      .o_fail        (lane_fail[i]),
      .o_busy        (w_busy[i])
    );
`else
    assign w_fsm_slip     = 1'b0;
    assign lane_locked[i] = 1'b0;
    assign lane_fail[i]   = 1'b0;
    assign w_busy[i]      = 1'b0;
`endif
  end

`ifndef LANE_AUTO_TRAIN_EN
  logic w_unused_train;
  assign w_unused_train = ^{train_start, train_pattern};
`endif

  assign out_valid  = r_out_valid;
  assign train_busy = |w_busy;

endmodule

// File: tb/tb_lane_word_aligner.sv
// tb/tb_lane_word_aligner.sv - directed self-checking bench for lane_word_aligner
module tb_lane_word_aligner;

  localparam int LANES = 8;
  localparam int W     = 16;
  localparam int OW    = 4;

  logic                  dco_clk       = 1'b0;
  logic                  rst           = 1'b1;
  logic [LANES-1:0]      in_rise       = '0;
  logic [LANES-1:0]      in_fall       = '0;
  logic [LANES-1:0]      bitslip_pulse = '0;
  logic                  train_start   = 1'b0;
  logic [W-1:0]          train_pattern = 16'hA5C3;
  logic [LANES*W-1:0]    out_word;
  logic                  out_valid;
  logic [LANES*OW-1:0]   slip_offset;
  logic [LANES-1:0]      lane_locked;
  logic [LANES-1:0]      lane_fail;
  logic                  train_busy;

  int       n_checks = 0;
  int       n_fails  = 0;
  int       tb_phase = 0;
  logic [W-1:0] pat_v = 16'hA5C3;
  int       lane_skew [LANES];
  bit       lane_zero [LANES];

  lane_word_aligner dut (
    .dco_clk       (dco_clk),
    .rst           (rst),
    .in_rise       (in_rise),
    .in_fall       (in_fall),
    .bitslip_pulse (bitslip_pulse),
    .train_start   (train_start),
    .train_pattern (train_pattern),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .slip_offset   (slip_offset),
    .lane_locked   (lane_locked),
    .lane_fail     (lane_fail),
    .train_busy    (train_busy)
  );

  always #5 dco_clk = ~dco_clk;

  always @(posedge dco_clk or posedge rst) begin
    if (rst) tb_phase = 0;
    else     tb_phase = (tb_phase + 1) % (W / 2);
  end

  // A lane with skew k carries the pattern advanced by k bits, so its true word sits at offset k.
  function automatic logic stream_bit(int lane, int b);
    if (lane_zero[lane]) return 1'b0;
    return pat_v[W - 1 - ((b + lane_skew[lane]) % W)];
  endfunction

  always @(negedge dco_clk) begin
    for (int i = 0; i < LANES; i++) begin
      in_rise[i] = stream_bit(i, 2 * tb_phase);
      in_fall[i] = stream_bit(i, 2 * tb_phase + 1);
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin
      @(posedge dco_clk);
      #1;
      n++;
    end while (!out_valid && n < 64);
    check("strobe_seen", out_valid, 1'b1);
  endtask

  task automatic pulse_train();
    @(negedge dco_clk);
    train_start = 1'b1;
    @(negedge dco_clk);
    train_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge dco_clk);
    rst = 1'b1;
    @(negedge dco_clk);
    @(negedge dco_clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    int n;
    for (int i = 0; i < LANES; i++) begin
      lane_skew[i] = 0;
      lane_zero[i] = 1'b0;
    end

    repeat (2) @(negedge dco_clk);
    check("rst_valid",  out_valid,   1'b0);
    check("rst_word",   out_word,    '0);
    check("rst_offset", slip_offset, '0);
    check("rst_locked", lane_locked, '0);
    check("rst_fail",   lane_fail,   '0);
    check("rst_busy",   train_busy,  1'b0);
    rst = 1'b0;

    cyc = 1;
    do begin
      @(posedge dco_clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 40);
    check("first_valid_cycle", cyc, 9);
    check("aligned_word", out_word, {8{16'hA5C3}});
    @(posedge dco_clk);
    #1;
    check("valid_width", out_valid, 1'b0);
    check("word_hold", out_word, {8{16'hA5C3}});
    cyc = 1;
    do begin
      @(posedge dco_clk);
      #1;
      cyc++;
    end while (!out_valid && cyc < 40);
    check("valid_period", cyc, 8);

    // Three slips on lane 0, fifteen on lane 3.
    for (int p = 0; p < 15; p++) begin
      @(negedge dco_clk);
      bitslip_pulse = (p < 3) ? 8'h09 : 8'h08;
      @(negedge dco_clk);
      bitslip_pulse = '0;
    end
    wait_strobe();
    wait_strobe();
    check("slip_offset", slip_offset, 32'h0000_F003);
    check("slip_word", out_word, {16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3,
                                  16'h4B87, 16'hA5C3, 16'hA5C3, 16'h74B8});
    @(negedge dco_clk);
    bitslip_pulse = 8'h08;
    @(negedge dco_clk);
    bitslip_pulse = '0;
    wait_strobe();
    wait_strobe();
    check("slip_wrap_offset", slip_offset, 32'h0000_0003);
    check("slip_wrap_word", out_word[3*W +: W], 16'hA5C3);

`ifdef LANE_AUTO_TRAIN_EN
    lane_skew[2] = 5;
    lane_zero[4] = 1'b1;
    do_reset();
    wait_strobe();
    pulse_train();
    for (int s = 1; s <= 32; s++) begin
      wait_strobe();
      if (s == 1)  check("train_busy_start", train_busy, 1'b1);
      if (s == 4)  check("lock0_early", lane_locked[0], 1'b0);
      if (s == 5) begin
        check("lock_at5", lane_locked, 8'hEB);
        check("offset_at5", slip_offset, 32'h0002_0200);
      end
      if (s == 14) check("lock2_early", lane_locked[2], 1'b0);
      if (s == 15) begin
        check("lock_at15", lane_locked, 8'hEF);
        check("offset2_at15", slip_offset[2*OW +: OW], 4'd5);
        check("word2_at15", out_word[2*W +: W], 16'hA5C3);
      end
      if (s == 31) begin
        check("fail4_early", lane_fail[4], 1'b0);
        check("busy_at31", train_busy, 1'b1);
      end
      if (s == 32) begin
        check("fail_at32", lane_fail, 8'h10);
        check("offset4_at32", slip_offset[4*OW +: OW], 4'd15);
        check("locked_at32", lane_locked, 8'hEF);
        check("busy_at32", train_busy, 1'b0);
      end
    end

    // Restart during CHECK, then a manual slip during SETTLE that must be dropped.
    do_reset();
    wait_strobe();
    pulse_train();
    repeat (3) wait_strobe();
    check("pre_restart_offset", slip_offset, 32'h0001_0100);
    @(negedge dco_clk);
    train_start = 1'b1;
    @(negedge dco_clk);
    train_start   = 1'b0;
    bitslip_pulse = 8'h04;
    @(negedge dco_clk);
    bitslip_pulse = '0;
    n = 0;
    do begin
      wait_strobe();
      n++;
    end while (!lane_locked[2] && n < 40);
    check("restart_lock_words", n, 13);
    check("restart_offsets", slip_offset, 32'h0007_0500);
    check("restart_locked", lane_locked, 8'hEF);
`else
    pulse_train();
    wait_strobe();
    check("notrain_busy", train_busy, 1'b0);
    repeat (20) wait_strobe();
    check("notrain_locked", lane_locked, '0);
    check("notrain_fail", lane_fail, '0);
    check("notrain_offset", slip_offset, 32'h0000_0003);
`endif

    wait_strobe();
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid",  out_valid,   1'b0);
    check("midrst_word",   out_word,    '0);
    check("midrst_offset", slip_offset, '0);
    check("midrst_locked", lane_locked, '0);
    check("midrst_fail",   lane_fail,   '0);
    check("midrst_busy",   train_busy,  1'b0);
    @(negedge dco_clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
